// File: rtl/uart_rx_to_axis.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, single-entry AXI-Stream output.
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s
// START  | half bit period, then confirm the start bit is still low
// DATA   | sample BIT_PER_WORD data bits, LSB first
// PARITY | sample parity bit and compare with the expected value
// STOP1  | sample first stop bit (0 -> framing error)
// STOP2  | sample second stop bit (0 -> framing error)
module uart_rx_to_axis #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    rx,
  output logic [BIT_PER_WORD-1:0] m_tdata,
  output logic [1:0]              m_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    overrun
);

  localparam int CYCLES = CLK_FREQ * 1_000_000 / BIT_RATE;
  localparam int HALF   = CYCLES / 2;
  localparam int TW     = 20;
  localparam logic [TW-1:0] LIM_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] LIM_BIT  = TW'(CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(BIT_PER_WORD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [BIT_PER_WORD-1:0] shreg_q, shreg_d;
  logic [BIT_PER_WORD-1:0] tdata_q, tdata_d;
  logic [1:0]              tuser_q, tuser_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    finish_q, finish_d;
  logic                    tvalid_q, tvalid_d;
  logic                    overrun_q, overrun_d;
  logic                    rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]           limit;
  logic                    tick;
  logic                    par_exp;

  always_comb begin
    limit     = (state_q == S_START) ? LIM_HALF : LIM_BIT;
    tick      = (timer_q == limit);
    par_exp   = (PARITY_BIT == 1) ? ~^shreg_q : ^shreg_q;
    state_d   = state_q;
    timer_d   = tick ? '0 : timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    finish_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // rx_prev_q must be high, so a held break never re-triggers
        if (rx_prev_q && !rx_s_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: if (tick) begin
        shreg_d   = {rx_s_q, shreg_q[BIT_PER_WORD-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == LAST_BIT) state_d = (PARITY_BIT != 0) ? S_PARITY : S_STOP1;
      end
      S_PARITY: if (tick) begin
        perr_d  = (rx_s_q != par_exp);
        state_d = S_STOP1;
      end
      S_STOP1: if (tick) begin
        if (!rx_s_q) ferr_d = 1'b1;
        if (STOP_BITS_NUM == 2) begin
          state_d = S_STOP2;
        end else begin
          state_d  = S_IDLE;
          finish_d = 1'b1;
        end
      end
      S_STOP2: if (tick) begin
        if (!rx_s_q) ferr_d = 1'b1;
        state_d  = S_IDLE;
        finish_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output slot: a finished word loads only if the slot is empty or being drained now
  always_comb begin
    tvalid_d  = tvalid_q & ~m_tready;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    overrun_d = 1'b0;
    if (finish_q) begin
      if (!tvalid_q || m_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = shreg_q;
        tuser_d  = {ferr_q, perr_q};
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      finish_q  <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      finish_q  <= finish_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tuser  = tuser_q;
  assign m_tvalid = tvalid_q;
  assign overrun  = overrun_q;

endmodule
